// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcodes, instruction classes and field bit positions.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    typedef enum logic [1:0] {
        CLASS_R = 2'b00,
        CLASS_I = 2'b01,
        CLASS_J = 2'b10
    } instr_class_e;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int IMM_MSB    = 15;
    localparam int TARGET_MSB = 25;

    function automatic instr_class_e classify(input logic [5:0] op);
        if (op == OP_RTYPE)
            return CLASS_R;
        else if (op == OP_J || op == OP_JAL)
            return CLASS_J;
        else
            return CLASS_I;
    endfunction

endpackage

// File: rtl/if_id_stage_skid_buffer.sv
// Two-entry valid/ready buffer: main entry drives the output, skid entry absorbs one
// beat of backpressure. in_ready is registered so it never depends on out_ready.
module skid_buffer #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             m_valid_q, m_valid_d;
    logic             s_valid_q, s_valid_d;
    logic [WIDTH-1:0] m_data_q,  m_data_d;
    logic [WIDTH-1:0] s_data_q,  s_data_d;
    logic             in_ready_q, in_ready_d;
    logic             accept, retire;

    assign accept = in_valid_i && in_ready_q;
    assign retire = m_valid_q && out_ready_i;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no latch is inferred.
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;

        if (flush_i) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            m_data_d  = RESET_VAL;
        end else if (!m_valid_q || (retire && !s_valid_q)) begin
            m_valid_d = accept;
            if (accept) m_data_d = in_data_i;
        end else if (retire) begin
            // Skid beat is older, so it moves up before the new beat is parked behind it.
            m_data_d  = s_data_q;
            s_valid_d = accept;
            if (accept) s_data_d = in_data_i;
        end else if (!s_valid_q) begin
            s_valid_d = accept;
            if (accept) s_data_d = in_data_i;
        end

        in_ready_d = !s_valid_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: data registers are reset too, because the output must read the reset value.
            m_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            m_data_q   <= RESET_VAL;
            s_data_q   <= RESET_VAL;
            in_ready_q <= 1'b0;
        end else begin
            m_valid_q  <= m_valid_d;
            s_valid_q  <= s_valid_d;
            m_data_q   <= m_data_d;
            s_data_q   <= s_data_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = m_valid_q;
    assign out_data_o  = m_data_q;

endmodule

// File: rtl/if_id_stage.sv
// Fetch-to-decode pipeline register: buffers {PC+4, instruction} and slices the held
// instruction into MIPS fields and an R/I/J class for the decode stage.
module if_id_stage
    import mips_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_instr,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc_plus4,
    output logic [5:0]            opcode,
    output logic [4:0]            rs,
    output logic [4:0]            rt,
    output logic [4:0]            rd,
    output logic [4:0]            shamt,
    output logic [5:0]            funct,
    output logic [15:0]           imm16,
    output logic [25:0]           target26,
    output logic [1:0]            instr_class
);

    localparam int W = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [W-1:0] RESET_VAL = {{ADDR_WIDTH{1'b0}}, NOP_INSTR};

    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [W-1:0]          out_data;

    // PC+4 is computed on entry so the buffer holds exactly what decode needs.
    assign pc_plus4 = in_pc + ADDR_WIDTH'(4);

    skid_buffer #(
        .WIDTH     (W),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   ({pc_plus4, in_instr}),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data)
    );

    assign out_instr    = out_data[DATA_WIDTH-1:0];
    assign out_pc_plus4 = out_data[W-1:DATA_WIDTH];

    assign opcode      = out_instr[OPCODE_MSB:OPCODE_LSB];
    assign rs          = out_instr[RS_MSB:RS_LSB];
    assign rt          = out_instr[RT_MSB:RT_LSB];
    assign rd          = out_instr[RD_MSB:RD_LSB];
    assign shamt       = out_instr[SHAMT_MSB:SHAMT_LSB];
    assign funct       = out_instr[FUNCT_MSB:0];
    assign imm16       = out_instr[IMM_MSB:0];
    assign target26    = out_instr[TARGET_MSB:0];
    assign instr_class = classify(opcode);

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch-to-decode pipeline register for the single-clock MIPS datapath.
- Sits directly upstream of signextend: accepts fetched instruction + PC, buffers it behind a valid/ready handshake, and presents decoded fields.
- imm16 feeds signextend; target26 feeds jump-address logic; register fields feed the regfile.
- Absorbs backpressure from decode with a 2-entry skid buffer; supports flush on taken branch/jump.

Parameters:
- DATA_WIDTH, 32, instruction width (fixed MIPS encoding; only 32 legal).
- ADDR_WIDTH, 32, PC width.
- NOP_INSTR, 32'h0000_0000, value driven on out_instr after reset and after flush.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents a beat.
- in_ready  out  1  stage can accept a beat.
- in_instr  in  DATA_WIDTH  fetched instruction.
- in_pc  in  ADDR_WIDTH  PC of in_instr.
- flush  in  1  discard all held beats, synchronous.
- out_valid  out  1  decoded beat available.
- out_ready  in  1  decode consumes the beat.
- out_instr  out  DATA_WIDTH  held instruction.
- out_pc_plus4  out  ADDR_WIDTH  held PC + 4, modulo 2^ADDR_WIDTH.
- opcode  out  6  out_instr[31:26].
- rs  out  5  out_instr[25:21].
- rt  out  5  out_instr[20:16].
- rd  out  5  out_instr[15:11].
- shamt  out  5  out_instr[10:6].
- funct  out  6  out_instr[5:0].
- imm16  out  16  out_instr[15:0], to signextend.
- target26  out  26  out_instr[25:0].
- instr_class  out  2  00 R (opcode 0); 10 J (opcode 2 or 3); 01 I (all others).

Behaviour:
- Reset (reset_n low, async):
  - out_valid=0; skid empty; in_ready=1 from the first edge after release.
  - out_instr=NOP_INSTR; out_pc_plus4=0; all fields derived accordingly.
- Storage: main register M (drives outputs) and skid register S; in_ready = !S_valid, registered.
- Accept: in_valid && in_ready at a rising edge.
- Latency: accepted beat appears on outputs the next cycle. Throughput is 1 beat/cycle when out_ready stays high.
- Out handshake: beat retires when out_valid && out_ready.
- Next-state rules, in priority order:
  - flush=1: M_valid=0, S_valid=0, out_instr=NOP_INSTR; any beat accepted in the same cycle is discarded. in_ready=1 next cycle.
  - M empty, or M retiring with S empty: accepted beat loads M.
  - M retiring with S full: S moves to M; accepted beat, if any, loads S.
  - M full, not retiring, S empty: accepted beat loads S; in_ready drops next cycle.
  - M and S full: in_ready=0, nothing accepted, state holds.
- Ordering: beats leave in acceptance order; no beat is dropped or duplicated except by flush.
- Field outputs are combinational slices of out_instr. They are meaningful only while out_valid=1; otherwise they hold the last value.
- in_valid may fall without acceptance; stage has no ordering requirement on in_valid vs in_ready.
- Reset mid-operation clears both entries immediately; no partial beat survives.

Decomposition:
- Package mips_pkg:
  - opcode constants OP_RTYPE=6'h00, OP_J=6'h02, OP_JAL=6'h03.
  - instr_class encodings CLASS_R, CLASS_I, CLASS_J.
  - field bit-position localparams.
- Sub-module skid_buffer: generic WIDTH-parameterised 2-entry valid/ready buffer with flush, carrying {pc_plus4, instr}.
- if_id_stage wraps skid_buffer, adds the PC+4 adder on input, and adds field/class decode on output.

Test Plan:
- Reset with in_valid=1 held: out_valid=0, out_instr=0x00000000, in_ready=1 one cycle after reset_n rises.
- in_instr=0x2109FFFF (addi $t1,$t0,-1), in_pc=0x00400000, out_ready=1: next cycle out_valid=1, opcode=0x08, rs=8, rt=9, imm16=0xFFFF, instr_class=01, out_pc_plus4=0x00400004.
- R/J decode:
  - 0x01095020 -> opcode=0, rs=8, rt=9, rd=10, shamt=0, funct=0x20, class=00.
  - 0x08100000 -> opcode=2, target26=0x0100000, class=10.
- Backpressure: out_ready=0, send A, B, C back-to-back -> A in M, B in S, in_ready=0, C held off. Raise out_ready -> outputs A, B, C in order with no gaps.
- Flush with M and S full plus in_valid=1: next cycle out_valid=0, out_instr=0, in_ready=1; the same-cycle input beat never appears.
- PC wrap: in_pc=0xFFFFFFFC -> out_pc_plus4=0x00000000.
